mxu_sequencer: RTL and testbench

- Bus-master controller that runs one full matrix multiply on the mxu without host involvement in its register protocol.
- Accepts a byte stream holding operands A then B, both row-major, and writes each element into the mxu operand map. It then programs the cycle count, issues start and waits out the compute window.
- Reads the SIZE*SIZE accumulator results back and returns them on a valid/ready result stream.
- Sits between the host/DMA side and the mxu write/read ports.

---
 rtl/mxu_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_mxu_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mxu_sequencer.sv
// mxu_sequencer: streams operands A then B into the mxu, programs and starts it,
// waits out the compute window, then reads the SIZE*SIZE results back as a stream.
module mxu_sequencer #(
    parameter int SIZE     = 4,
    parameter int CYCLES   = 20,
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic [31:0] m_awaddr,
    output logic [7:0]  m_wdata,
    output logic        m_wready,
    output logic [31:0] m_araddr,
    output logic        m_arready,
    output logic        m_rready,
    input  logic [31:0] m_rdata
);
    localparam int N_EL   = SIZE * SIZE;
    localparam int N_OP   = 2 * N_EL;
    localparam int WAIT_N = 3 * CYCLES + 5;
    localparam int E_W    = $clog2(N_OP + 1);
    localparam int K_W    = $clog2(N_EL + 1);
    localparam int W_W    = $clog2(WAIT_N + 1);
    localparam int R_W    = $clog2(READ_LAT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ACCEPT, S_WSETUP, S_WSTROBE, S_WHOLD, S_CFG,
        S_GO, S_WAIT, S_RREQ, S_RWAIT, S_ROUT, S_FIN
    } state_e;

    // Which write is in flight, so WHOLD knows where to go next.
    typedef enum logic [1:0] {WK_LOAD, WK_CFG, WK_GO} wkind_e;

    state_e      state_q, state_d;
    wkind_e      kind_q, kind_d;
    logic [E_W-1:0] e_q, e_d;
    logic [K_W-1:0] k_q, k_d;
    logic [W_W-1:0] wait_q, wait_d;
    logic [R_W-1:0] rd_q, rd_d;
    logic        busy_q, busy_d, done_q, done_d, in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [31:0] out_data_q, out_data_d, awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        wready_q, wready_d, arready_q, arready_d;

    // Both streams transfer a beat on a rising edge where valid and ready are
    // both high; the sender holds data (and out_last) stable until that edge.
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        e_d         = e_q;
        k_d         = k_q;
        wait_d      = wait_q;
        rd_d        = rd_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        in_ready_d  = 1'b0;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wready_d    = 1'b0;
        araddr_d    = araddr_q;
        arready_d   = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) begin
                busy_d     = 1'b1;
                e_d        = '0;
                k_d        = '0;
                in_ready_d = 1'b1;
                state_d    = S_ACCEPT;
            end
            S_ACCEPT: if (in_valid && in_ready_q) begin
                awaddr_d = 32'd2 + 32'(e_q);
                wdata_d  = in_data;
                kind_d   = WK_LOAD;
                state_d  = S_WSETUP;
            end else begin
                in_ready_d = 1'b1;
            end
            S_WSETUP: begin
                wready_d = 1'b1;
                state_d  = S_WSTROBE;
            end
            S_WSTROBE: state_d = S_WHOLD;
            S_WHOLD: begin
                unique case (kind_q)
                    WK_LOAD: begin
                        e_d = e_q + E_W'(1);
                        if (e_q == E_W'(N_OP - 1)) begin
                            state_d = S_CFG;
                        end else begin
                            in_ready_d = 1'b1;
                            state_d    = S_ACCEPT;
                        end
                    end
                    WK_CFG:  state_d = S_GO;
                    default: begin
                        wait_d  = '0;
                        state_d = S_WAIT;
                    end
                endcase
            end
            S_CFG: begin
                awaddr_d = 32'd1;
                wdata_d  = 8'(CYCLES);
                kind_d   = WK_CFG;
                state_d  = S_WSETUP;
            end
            S_GO: begin
                awaddr_d = 32'd0;
                wdata_d  = 8'h01;
                kind_d   = WK_GO;
                state_d  = S_WSETUP;
            end
            // The cycle in RREQ closes the window, so WAIT itself runs one short.
            S_WAIT: if (wait_q == W_W'(WAIT_N - 2)) begin
                araddr_d  = 32'd1 + 32'(k_q);
                arready_d = 1'b1;
                state_d   = S_RREQ;
            end else begin
                wait_d = wait_q + W_W'(1);
            end
            S_RREQ: begin
                rd_d    = '0;
                state_d = S_RWAIT;
            end
            S_RWAIT: if (rd_q == R_W'(READ_LAT - 1)) begin
                out_data_d  = m_rdata;
                out_valid_d = 1'b1;
                out_last_d  = (k_q == K_W'(N_EL - 1));
                state_d     = S_ROUT;
            end else begin
                rd_d = rd_q + R_W'(1);
            end
            S_ROUT: if (out_ready) begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                k_d         = k_q + K_W'(1);
                if (out_last_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FIN;
                end else begin
                    araddr_d  = 32'd2 + 32'(k_q);
                    arready_d = 1'b1;
                    state_d   = S_RREQ;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            kind_q      <= WK_LOAD;
            e_q         <= '0;
            k_q         <= '0;
            wait_q      <= '0;
            rd_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wready_q    <= 1'b0;
            araddr_q    <= '0;
            arready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            e_q         <= e_d;
            k_q         <= k_d;
            wait_q      <= wait_d;
            rd_q        <= rd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wready_q    <= wready_d;
            araddr_q    <= araddr_d;
            arready_q   <= arready_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign m_awaddr  = awaddr_q;
    assign m_wdata   = wdata_q;
    assign m_wready  = wready_q;
    assign m_araddr  = araddr_q;
    assign m_arready = arready_q;
    assign m_rready  = 1'b0;
endmodule

// File: tb/tb_mxu_sequencer.sv
// Directed bench for mxu_sequencer: behavioural mxu, bus monitor, and checks of
// reset, operand load, config/start timing, result stream, backpressure and done.
module tb_mxu_sequencer;
    localparam int SIZE     = 4;
    localparam int CYCLES   = 20;
    localparam int READ_LAT = 2;
    localparam int N_EL     = SIZE * SIZE;
    localparam int N_OP     = 2 * N_EL;

    logic        clk = 1'b0;
    logic        reset, start, busy, done;
    logic        in_valid, in_ready;
    logic [7:0]  in_data;
    logic        out_valid, out_ready, out_last;
    logic [31:0] out_data;
    logic [31:0] m_awaddr, m_araddr;
    logic [7:0]  m_wdata;
    logic        m_wready, m_arready, m_rready;
    logic [31:0] m_rdata = 32'hDEAD_BEEF;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] a_arr [N_EL] = '{8'd5, 8'd2, 8'd6, 8'd1, 8'd0, 8'd6, 8'd2, 8'd0,
                                 8'd3, 8'd8, 8'd1, 8'd4, 8'd1, 8'd8, 8'd5, 8'd6};
    logic [7:0] b_arr [N_EL] = '{8'd7, 8'd5, 8'd8, 8'd0, 8'd1, 8'd8, 8'd2, 8'd6,
                                 8'd9, 8'd4, 8'd3, 8'd8, 8'd5, 8'd3, 8'd7, 8'd9};

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    int          wr_cyc_q[$];
    logic [31:0] rd_addr_q[$];
    int          rd_cyc_q[$];
    int          wide_cnt = 0;
    int          hold_err = 0;

    mxu_sequencer #(.SIZE(SIZE), .CYCLES(CYCLES), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .m_awaddr(m_awaddr), .m_wdata(m_wdata),
        .m_wready(m_wready), .m_araddr(m_araddr), .m_arready(m_arready),
        .m_rready(m_rready), .m_rdata(m_rdata)
    );

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural mxu: captures writes, computes A*B on start, returns reads READ_LAT later.
    logic [7:0]  mem [64];
    logic [31:0] res [N_EL];
    int          rd_cnt = 0;
    int          rd_idx = 0;
    always @(negedge clk) begin
        if (m_wready && m_awaddr < 32'd64) begin
            mem[m_awaddr[5:0]] = m_wdata;
            if (m_awaddr == 32'd0 && m_wdata == 8'd1) begin
                for (int i = 0; i < SIZE; i++) begin
                    for (int j = 0; j < SIZE; j++) begin
                        logic [31:0] acc;
                        acc = 32'd0;
                        for (int t = 0; t < SIZE; t++)
                            acc = acc + 32'(mem[6'(2 + i * SIZE + t)]) * 32'(mem[6'(2 + N_EL + t * SIZE + j)]);
                        res[4'(i * SIZE + j)] = acc;
                    end
                end
            end
        end
        m_rdata = 32'hDEAD_BEEF;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0 && rd_idx >= 0 && rd_idx < N_EL) m_rdata = res[4'(rd_idx)];
        end
        if (m_arready) begin
            rd_cnt = READ_LAT;
            rd_idx = int'(m_araddr) - 1;
        end
    end

    // Bus monitor
    logic        prev_w = 1'b0, prev_r = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic [7:0]  prev_data = 8'd0;
    always @(negedge clk) begin
        if (m_wready) begin
            wr_addr_q.push_back(m_awaddr);
            wr_data_q.push_back(m_wdata);
            wr_cyc_q.push_back(cyc);
        end
        if (m_arready) begin
            rd_addr_q.push_back(m_araddr);
            rd_cyc_q.push_back(cyc);
        end
        if (m_wready && prev_w) wide_cnt++;
        if (m_arready && prev_r) wide_cnt++;
        if (prev_w && (m_awaddr !== prev_addr || m_wdata !== prev_data)) hold_err++;
        prev_w    = m_wready;
        prev_r    = m_arready;
        prev_addr = m_awaddr;
        prev_data = m_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] op_byte(input int n);
        return (n < N_EL) ? a_arr[4'(n)] : b_arr[4'(n - N_EL)];
    endfunction

    task automatic fill_exp();
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                logic [31:0] acc;
                acc = 32'd0;
                for (int t = 0; t < SIZE; t++)
                    acc = acc + 32'(a_arr[4'(i * SIZE + t)]) * 32'(b_arr[4'(t * SIZE + j)]);
                exp_q.push_back(acc);
            end
        end
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        rd_addr_q.delete();
        rd_cyc_q.delete();
        wide_cnt = 0;
        hold_err = 0;
    endtask

    // Driver tasks: entered and left at posedge+2.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        in_valid = 1'b1;
        in_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #2;
    endtask

    task automatic load_all(input bit gaps, input int count);
        bit ok;
        int fails;
        fails = 0;
        for (int n = 0; n < count; n++) begin
            send_byte(op_byte(n), ok);
            if (!ok) fails++;
            if (gaps && (n % 3 == 1)) begin
                in_valid = 1'b0;
                in_data  = 8'hEE;
                repeat (5) @(posedge clk);
                #2;
            end
        end
        in_valid = 1'b0;
        chk("load_accept_timeouts", 32'(fails), 32'd0);
    endtask

    task automatic collect(input bit stall, input bit start_at_fin);
        int nw, ndone, stall_n, budget;
        logic [31:0] held;
        nw = 0; ndone = 0; stall_n = 0; held = 32'd0;
        out_ready = 1'b1;
        for (budget = 0; budget < 3000 && ndone == 0; budget++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                chk("done_busy_low", 32'(busy), 32'd0);
                chk("done_word_count", 32'(nw), 32'(N_EL));
                if (start_at_fin) start = 1'b1;
            end else if (out_valid) begin
                if (stall && nw == 3 && stall_n < 10) begin
                    if (stall_n == 0) held = out_data;
                    else chk("stall_data_stable", out_data, held);
                    out_ready = 1'b0;
                    stall_n++;
                end else begin
                    out_ready = 1'b1;
                    chk("result_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) chk("result_word", out_data, exp_q.pop_front());
                    chk("result_last", 32'(out_last), 32'(nw == N_EL - 1));
                    got_q.push_back(out_data);
                    nw++;
                end
            end
        end
        chk("done_seen", 32'(ndone), 32'd1);
        @(posedge clk); #2;
        start = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("done_single_pulse", 32'(ndone), 32'd1);
        chk("idle_busy_low", 32'(busy), 32'd0);
        chk("idle_in_ready_low", 32'(in_ready), 32'd0);
        chk("all_results_consumed", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #2;
    endtask

    task automatic check_bus(input string job);
        int bad;
        chk({job, "_write_count"}, 32'(wr_addr_q.size()), 32'(N_OP + 2));
        chk({job, "_read_count"}, 32'(rd_addr_q.size()), 32'(N_EL));
        chk({job, "_strobe_width"}, 32'(wide_cnt), 32'd0);
        chk({job, "_whold_stable"}, 32'(hold_err), 32'd0);
        bad = 0;
        for (int n = 0; n < N_OP && n < wr_addr_q.size(); n++)
            if (wr_addr_q[n] !== 32'(n + 2) || wr_data_q[n] !== op_byte(n)) bad++;
        chk({job, "_load_sequence"}, 32'(bad), 32'd0);
        bad = 0;
        for (int k = 0; k < rd_addr_q.size(); k++)
            if (rd_addr_q[k] !== 32'(k + 1)) bad++;
        chk({job, "_read_addresses"}, 32'(bad), 32'd0);
        if (wr_addr_q.size() == N_OP + 2) begin
            chk({job, "_cfg_addr"}, wr_addr_q[N_OP], 32'd1);
            chk({job, "_cfg_data"}, 32'(wr_data_q[N_OP]), 32'd20);
            chk({job, "_go_addr"}, wr_addr_q[N_OP + 1], 32'd0);
            chk({job, "_go_data"}, 32'(wr_data_q[N_OP + 1]), 32'd1);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs_zero", 32'(|{busy, done, in_ready, out_valid, out_last, out_data,
                                       m_awaddr, m_wdata, m_wready, m_araddr, m_arready, m_rready}), 32'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        chk("idle_in_ready_before_start", 32'(in_ready), 32'd0);

        // Abort a load after 5 bytes with an asynchronous reset
        pulse_start();
        chk("start_sets_busy", 32'(busy), 32'd1);
        load_all(1'b0, 5);
        chk("mid_load_awaddr", m_awaddr, 32'd6);
        #4 reset = 1'b0;
        #1;
        chk("async_reset_outputs_zero", 32'(|{busy, done, in_ready, out_valid, out_last, out_data,
                                             m_awaddr, m_wdata, m_wready, m_araddr, m_arready, m_rready}), 32'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        in_valid = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            chk("post_reset_in_ready", 32'(in_ready), 32'd0);
            chk("post_reset_busy", 32'(busy), 32'd0);
        end
        in_valid = 1'b0;
        @(posedge clk); #2;

        // Job 1: in_valid held high, no backpressure, start repeated while busy
        clear_mon();
        fill_exp();
        pulse_start();
        chk("job1_busy", 32'(busy), 32'd1);
        load_all(1'b0, N_OP);
        pulse_start();
        chk("busy_start_ignored", 32'(busy), 32'd1);
        collect(1'b0, 1'b0);
        check_bus("job1");
        if (wr_addr_q.size() >= N_OP) begin
            chk("first_strobe_addr", wr_addr_q[0], 32'd2);
            chk("first_strobe_data", 32'(wr_data_q[0]), 32'd5);
            chk("b0_strobe_addr", wr_addr_q[16], 32'd18);
            chk("b0_strobe_data", 32'(wr_data_q[16]), 32'd7);
            chk("last_strobe_addr", wr_addr_q[N_OP - 1], 32'd33);
            chk("last_strobe_data", 32'(wr_data_q[N_OP - 1]), 32'd9);
            begin
                int bad;
                bad = 0;
                for (int n = 0; n < N_OP - 1; n++)
                    if (wr_cyc_q[n + 1] - wr_cyc_q[n] != 4) bad++;
                chk("load_4_clocks_per_element", 32'(bad), 32'd0);
            end
        end
        if (wr_cyc_q.size() == N_OP + 2 && rd_cyc_q.size() > 0) begin
            // Strobe, then WHOLD, then 65 clocks to the first read strobe.
            chk("first_arready_delay", 32'(rd_cyc_q[0] - wr_cyc_q[N_OP + 1]), 32'd66);
            chk("first_araddr", rd_addr_q[0], 32'd1);
        end
        if (got_q.size() >= 4) begin
            chk("c00", got_q[0], 32'd96);
            chk("c01", got_q[1], 32'd68);
            chk("c02", got_q[2], 32'd69);
            chk("c03", got_q[3], 32'd69);
        end
        chk("job1_word_total", 32'(got_q.size()), 32'(N_EL));

        // Job 2: toggled in_valid, 10-cycle stall on word 3, start during FIN
        clear_mon();
        fill_exp();
        pulse_start();
        load_all(1'b1, N_OP);
        collect(1'b1, 1'b1);
        check_bus("job2");
        chk("job2_word_total", 32'(got_q.size()), 32'(N_EL));
        if (got_q.size() >= 4) chk("job2_stalled_word", got_q[3], 32'd69);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
